// File: rtl/score_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// score_accumulator_pkg
// Shared definitions for the score accumulator: FSM state encoding, BCD
// types and limits, digit index constants and a BCD magnitude compare.
// No ports (package).
// ---------------------------------------------------------------------------
package score_accumulator_pkg;

  typedef logic [15:0] bcd_t;    // {thousands, hundreds, tens, ones}
  typedef logic [3:0]  digit_t;  // one BCD digit, 0..9

  // Add sequence: IDLE -> ADD0 -> ADD1 -> ADD2 -> ADD3 -> COMMIT -> IDLE
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ADD0   = 3'd1;
  localparam logic [2:0] ST_ADD1   = 3'd2;
  localparam logic [2:0] ST_ADD2   = 3'd3;
  localparam logic [2:0] ST_ADD3   = 3'd4;
  localparam logic [2:0] ST_COMMIT = 3'd5;

  localparam bcd_t BCD_MAX = 16'h9999;

  localparam int DIG_ONES      = 0;
  localparam int DIG_TENS      = 1;
  localparam int DIG_HUNDREDS  = 2;
  localparam int DIG_THOUSANDS = 3;
  localparam int NUM_DIGITS    = 4;

  // a > b for valid BCD words, decided by the most significant differing digit.
  function automatic logic bcd_gt(input bcd_t a, input bcd_t b);
    logic decided;
    logic gt;
    decided = 1'b0;
    gt      = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (!decided && (a[i*4 +: 4] != b[i*4 +: 4])) begin
        decided = 1'b1;
        gt      = (a[i*4 +: 4] > b[i*4 +: 4]);
      end
    end
    return gt;
  endfunction

endpackage

// File: rtl/score_accumulator_if.sv
// ---------------------------------------------------------------------------
// score_accumulator_if
// Bundles the game-logic side of the score accumulator.
//   master (game logic / bench): drives hit, get_score, game_end, clear;
//                                observes score_bcd, high_bcd, score_signal,
//                                update, busy, overflow, dropped.
//   slave  (score_accumulator):  the reverse directions.
// ---------------------------------------------------------------------------
interface score_accumulator_if;
  import score_accumulator_pkg::*;

  logic       hit;           // raw asynchronous hit level
  logic [3:0] get_score;     // points for the hit, binary 0..15
  logic       game_end;      // blocks acceptance of new hits
  logic       clear;         // synchronous score clear
  bcd_t       score_bcd;     // registered BCD score
  bcd_t       high_bcd;      // highest score since reset
  logic       score_signal;  // toggles per committed update
  logic       update;        // one-clock pulse when score_bcd changes
  logic       busy;          // add sequence in progress
  logic       overflow;      // sticky wrap/clamp flag
  logic       dropped;       // sticky lost-hit flag

  modport master (
    output hit, get_score, game_end, clear,
    input  score_bcd, high_bcd, score_signal, update, busy, overflow, dropped
  );

  modport slave (
    input  hit, get_score, game_end, clear,
    output score_bcd, high_bcd, score_signal, update, busy, overflow, dropped
  );
endinterface

// File: rtl/score_accumulator_bcd_digit_add.sv
// ---------------------------------------------------------------------------
// bcd_digit_add
// Combinational single-digit BCD add: digit_i + addend_i, addend up to 15.
//   digit_i   in  4  BCD digit 0..9
//   addend_i  in  4  points (first digit) or ripple carry (later digits)
//   digit_o   out 4  (digit_i + addend_i) mod 10
//   carry_o   out 2  (digit_i + addend_i) / 10, 0..2
// ---------------------------------------------------------------------------
module bcd_digit_add
  import score_accumulator_pkg::*;
(
  input  digit_t     digit_i,
  input  logic [3:0] addend_i,
  output digit_t     digit_o,
  output logic [1:0] carry_o
);
  logic [4:0] sum;

  always_comb begin
    sum = {1'b0, digit_i} + {1'b0, addend_i};
    if (sum >= 5'd20) begin
      carry_o = 2'd2;
      digit_o = 4'(sum - 5'd20);
    end else if (sum >= 5'd10) begin
      carry_o = 2'd1;
      digit_o = 4'(sum - 5'd10);
    end else begin
      carry_o = 2'd0;
      digit_o = sum[3:0];
    end
  end
endmodule

// File: rtl/score_accumulator.sv
// ---------------------------------------------------------------------------
// score_accumulator
// Turns raw hit events into a registered 4-digit BCD score using a
// four-cycle digit-serial ripple add, with a one-deep pending slot, a high
// score register and sticky overflow/dropped flags.
//   clk   in  system clock
//   rst   in  asynchronous active-low reset
//   bus   slave modport of score_accumulator_if (hit/get_score/game_end/
//         clear in; score_bcd/high_bcd/score_signal/update/busy/overflow/
//         dropped out)
// Parameters: SYNC_STAGES (>=2) hit synchronizer depth; SATURATE 1 clamps
// at 9999, 0 wraps modulo 10000.
// ---------------------------------------------------------------------------
module score_accumulator
  import score_accumulator_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit SATURATE    = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  score_accumulator_if.slave bus
);
  // Input path
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_prev_q;
  logic                   hit_edge;
  logic                   accepted;

  // Add sequence state
  logic [2:0]       state_q, state_d;
  logic [3:0]       pts_q, pts_d;
  logic [1:0]       carry_q, carry_d;
  logic [3:0][3:0]  scratch_q, scratch_d;
  logic             pend_valid_q, pend_valid_d;
  logic [3:0]       pend_pts_q, pend_pts_d;

  // Outputs
  bcd_t score_q, score_d;
  bcd_t high_q, high_d;
  logic signal_q, signal_d;
  logic update_q, update_d;
  logic overflow_q, overflow_d;
  logic dropped_q, dropped_d;

  // Shared digit adder
  logic [1:0] add_idx;
  digit_t     add_sum;
  logic [1:0] add_carry;
  logic [3:0] add_b;
  bcd_t       commit_val;

  assign hit_edge = sync_q[SYNC_STAGES-1] & ~edge_prev_q;
  assign accepted = hit_edge & ~bus.game_end & ~bus.clear & (bus.get_score != 4'd0);

  always_comb begin
    case (state_q)
      ST_ADD1: add_idx = 2'(DIG_TENS);
      ST_ADD2: add_idx = 2'(DIG_HUNDREDS);
      ST_ADD3: add_idx = 2'(DIG_THOUSANDS);
      default: add_idx = 2'(DIG_ONES);
    endcase
  end

  // ADD0 adds the points; later digits only absorb the ripple carry.
  assign add_b = (state_q == ST_ADD0) ? pts_q : {2'b00, carry_q};

  bcd_digit_add u_digit_add (
    .digit_i  (scratch_q[add_idx]),
    .addend_i (add_b),
    .digit_o  (add_sum),
    .carry_o  (add_carry)
  );

  // Carry out of the thousands digit means the result passed 9999.
  assign commit_val = ((carry_q != 2'd0) && SATURATE) ? BCD_MAX : bcd_t'(scratch_q);

  always_comb begin
    state_d      = state_q;
    pts_d        = pts_q;
    carry_d      = carry_q;
    scratch_d    = scratch_q;
    pend_valid_d = pend_valid_q;
    pend_pts_d   = pend_pts_q;
    score_d      = score_q;
    high_d       = high_q;
    signal_d     = signal_q;
    update_d     = 1'b0;
    overflow_d   = overflow_q;
    dropped_d    = dropped_q;

    if (bus.clear) begin
      // Clear wins over everything, including a COMMIT in the same cycle.
      state_d      = ST_IDLE;
      pend_valid_d = 1'b0;
      score_d      = '0;
      overflow_d   = 1'b0;
      dropped_d    = 1'b0;
      if (score_q != '0) begin
        signal_d = ~signal_q;
        update_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pend_valid_q || accepted) begin
            state_d   = ST_ADD0;
            scratch_d = score_q;
            carry_d   = 2'd0;
            if (pend_valid_q) begin
              // Pending entry goes first; a fresh edge refills the slot.
              pts_d        = pend_pts_q;
              pend_valid_d = accepted;
              pend_pts_d   = bus.get_score;
            end else begin
              pts_d = bus.get_score;
            end
          end
        end
        ST_ADD0, ST_ADD1, ST_ADD2, ST_ADD3: begin
          scratch_d[add_idx] = add_sum;
          carry_d            = add_carry;
          state_d            = state_q + 3'd1;
        end
        ST_COMMIT: begin
          score_d  = commit_val;
          signal_d = ~signal_q;
          update_d = 1'b1;
          if (carry_q != 2'd0) overflow_d = 1'b1;
          if (bcd_gt(commit_val, high_q)) high_d = commit_val;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase

      if (accepted && (state_q != ST_IDLE)) begin
        if (pend_valid_q) begin
          dropped_d = 1'b1;
        end else begin
          pend_valid_d = 1'b1;
          pend_pts_d   = bus.get_score;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q       <= '0;
      edge_prev_q  <= 1'b0;
      state_q      <= ST_IDLE;
      pts_q        <= '0;
      carry_q      <= '0;
      scratch_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_pts_q   <= '0;
      score_q      <= '0;
      high_q       <= '0;
      signal_q     <= 1'b0;
      update_q     <= 1'b0;
      overflow_q   <= 1'b0;
      dropped_q    <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], bus.hit};
      edge_prev_q  <= sync_q[SYNC_STAGES-1];
      state_q      <= state_d;
      pts_q        <= pts_d;
      carry_q      <= carry_d;
      scratch_q    <= scratch_d;
      pend_valid_q <= pend_valid_d;
      pend_pts_q   <= pend_pts_d;
      score_q      <= score_d;
      high_q       <= high_d;
      signal_q     <= signal_d;
      update_q     <= update_d;
      overflow_q   <= overflow_d;
      dropped_q    <= dropped_d;
    end
  end

  assign bus.score_bcd    = score_q;
  assign bus.high_bcd     = high_q;
  assign bus.score_signal = signal_q;
  assign bus.update       = update_q;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.overflow     = overflow_q;
  assign bus.dropped      = dropped_q;
endmodule
